// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: widths, opcode field position, NOP encoding
// and the fetch-stage state type.
package pipeline_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int INSTR_WIDTH = 16;
    localparam int OPCODE_MSB  = 15;
    localparam int OPCODE_LSB  = 11;
    localparam int OPCODE_W    = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR  = 16'h0000;
    localparam logic [OPCODE_W-1:0]    HLT_OPCODE = 5'b00001;

    typedef enum logic [1:0] {
        VEC_HI = 2'd0,
        VEC_LO = 2'd1,
        RUN    = 2'd2,
        HALT   = 2'd3
    } fetch_state_t;

    // Sequential successor of a PC; wraps silently at the top of the address space.
    function automatic logic [PC_WIDTH-1:0] pc_incr(input logic [PC_WIDTH-1:0] pc);
        return pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage and its neighbours: hazard/redirect controls,
// instruction memory port and the F/D buffer feed.
interface fetch_stage_if;
    import pipeline_pkg::*;

    logic                   stall;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic [INSTR_WIDTH-1:0] instruction_out;
    logic [PC_WIDTH-1:0]    PC_out;
    logic                   flush_out;
    logic                   halted;

    modport master (
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        input  imem_rdata,
        output imem_addr,
        output instruction_out,
        output PC_out,
        output flush_out,
        output halted
    );

    modport slave (
        output stall,
        output redirect_valid,
        output redirect_pc,
        output imem_rdata,
        input  imem_addr,
        input  instruction_out,
        input  PC_out,
        input  flush_out,
        input  halted
    );

endinterface

// File: rtl/pc_reg.sv
// Program counter register with half-word loads for reset-vector fetch,
// full load for redirects, increment and hold.
module pc_reg
    import pipeline_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_hi,
    input  logic                   load_lo,
    input  logic                   load_full,
    input  logic                   inc,
    input  logic                   hold,
    input  logic [INSTR_WIDTH-1:0] half_in,
    input  logic [PC_WIDTH-1:0]    full_in,
    output logic [PC_WIDTH-1:0]    pc
);

    logic [PC_WIDTH-1:0] pc_r;

    // PC update; a redirect load outranks everything, hold outranks increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= {PC_WIDTH{1'b0}};
        end else if (load_full) begin
            pc_r <= full_in;
        end else if (load_hi) begin
            pc_r[PC_WIDTH-1 -: INSTR_WIDTH] <= half_in;
        end else if (load_lo) begin
            pc_r[INSTR_WIDTH-1:0] <= half_in;
        end else if (hold) begin
            pc_r <= pc_r;
        end else if (inc) begin
            pc_r <= pc_incr(pc_r);
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: boots the PC from the in-memory reset vector, then fetches one
// word per cycle, honouring stalls, redirects and the HLT instruction.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_VEC_ADDR = {PC_WIDTH{1'b0}},
    parameter logic [OPCODE_W-1:0] HLT_OPCODE     = pipeline_pkg::HLT_OPCODE
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master fs
);

    localparam logic [PC_WIDTH-1:0] VEC_LO_ADDR = RESET_VEC_ADDR + {{(PC_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_t           state_r;
    fetch_state_t           state_nxt_s;
    logic                   load_hi_s;
    logic                   load_lo_s;
    logic                   load_full_s;
    logic                   inc_s;
    logic                   hold_s;
    logic [PC_WIDTH-1:0]    pc_s;
    logic [PC_WIDTH-1:0]    imem_addr_s;
    logic [INSTR_WIDTH-1:0] instr_s;
    logic                   flush_s;
    logic                   halted_s;
    logic [OPCODE_W-1:0]    opcode_s;

    assign opcode_s = fs.imem_rdata[OPCODE_MSB:OPCODE_LSB];

    pc_reg u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_hi   (load_hi_s),
        .load_lo   (load_lo_s),
        .load_full (load_full_s),
        .inc       (inc_s),
        .hold      (hold_s),
        .half_in   (fs.imem_rdata),
        .full_in   (fs.redirect_pc),
        .pc        (pc_s)
    );

    // State register; reset always restarts the vector fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= VEC_HI;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, PC control and output muxing
    always_comb begin
        state_nxt_s = state_r;
        load_hi_s   = 1'b0;
        load_lo_s   = 1'b0;
        load_full_s = 1'b0;
        inc_s       = 1'b0;
        hold_s      = 1'b1;
        imem_addr_s = pc_s;
        instr_s     = NOP_INSTR;
        flush_s     = 1'b1;
        halted_s    = 1'b0;
        case (state_r)
            VEC_HI: begin
                imem_addr_s = RESET_VEC_ADDR;
                load_hi_s   = 1'b1;
                hold_s      = 1'b0;
                state_nxt_s = VEC_LO;
            end
            VEC_LO: begin
                imem_addr_s = VEC_LO_ADDR;
                load_lo_s   = 1'b1;
                hold_s      = 1'b0;
                state_nxt_s = RUN;
            end
            RUN: begin
                // The HLT word itself is forwarded; NOPs start the cycle after
                instr_s = fs.imem_rdata;
                flush_s = fs.redirect_valid;
                hold_s  = 1'b0;
                if (fs.redirect_valid) begin
                    load_full_s = 1'b1;
                end else if (fs.stall) begin
                    hold_s = 1'b1;
                end else if (opcode_s == HLT_OPCODE) begin
                    inc_s       = 1'b1;
                    state_nxt_s = HALT;
                end else begin
                    inc_s = 1'b1;
                end
            end
            HALT: begin
                halted_s = 1'b1;
                if (fs.redirect_valid) begin
                    load_full_s = 1'b1;
                    hold_s      = 1'b0;
                    state_nxt_s = RUN;
                end else begin
                    hold_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = VEC_HI;
            end
        endcase
    end

    assign fs.imem_addr       = imem_addr_s;
    assign fs.instruction_out = instr_s;
    assign fs.PC_out          = pc_s;
    assign fs.flush_out       = flush_s;
    assign fs.halted          = halted_s;

endmodule
